// File: rtl/jump_ctrl_if.sv
// Instruction-in / jump-control-out bundle between the fetch datapath and jump_ctrl.
// master = datapath side (drives Instr and flag writes), slave = jump_ctrl.
interface jump_ctrl_if #(
  parameter int PCW  = 16,
  parameter int IW   = 9,
  parameter int CNTW = 16
);
  logic [IW-1:0]   Instr;
  logic            Instr_Valid;
  logic            Flag_We;
  logic            Flag_In;
  logic            For_Jump;
  logic            Back_Jump;
  logic [PCW-1:0]  Offset;
  logic            Halt;
  logic            Squash;
  logic [CNTW-1:0] Instr_Count;
  logic [CNTW-1:0] Jump_Count;

  modport master (
    output Instr, Instr_Valid, Flag_We, Flag_In,
    input  For_Jump, Back_Jump, Offset, Halt, Squash, Instr_Count, Jump_Count
  );

  modport slave (
    input  Instr, Instr_Valid, Flag_We, Flag_In,
    output For_Jump, Back_Jump, Offset, Halt, Squash, Instr_Count, Jump_Count
  );
endinterface

// File: rtl/jump_ctrl.sv
// Branch/halt decoder driving the PC's jump and freeze controls; outputs one cycle after decode.
// No backpressure: one instruction per cycle, bubbles via Instr_Valid, shadow slot squashed.
module jump_ctrl #(
  parameter int PCW  = 16,
  parameter int IW   = 9,
  parameter int CNTW = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  jump_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, SHADOW, HALTED} state_t;

  state_t          state, state_nxt;
  logic            flag;
  logic            eff_flag;
  logic            is_branch;
  logic            is_halt;
  logic            taken;
  logic            decode;
  logic            fj_nxt;
  logic            bj_nxt;
  logic [PCW-1:0]  imm_ext;
  logic [PCW-1:0]  off_nxt;
  logic            for_jump_q;
  logic            back_jump_q;
  logic            halt_q;
  logic [PCW-1:0]  offset_q;
  logic [CNTW-1:0] icnt_q;
  logic [CNTW-1:0] jcnt_q;

  always_comb begin
    eff_flag  = bus.Flag_We ? bus.Flag_In : flag;
    is_branch = (bus.Instr[8:6] == 3'b111);
    is_halt   = (bus.Instr[8:0] == 9'd0);
    taken     = is_branch && (!bus.Instr[4] || eff_flag);
    decode    = (state == RUN) && bus.Instr_Valid;
    imm_ext   = PCW'(bus.Instr[3:0]);

    state_nxt = state;
    fj_nxt    = 1'b0;
    bj_nxt    = 1'b0;
    off_nxt   = '0;

    case (state)
      RUN: begin
        if (decode && taken) begin
          state_nxt = SHADOW;
          // PC has already advanced to N+1 when the pulse lands, so
          // forward needs d-1 and back needs d+1, with d = imm+1.
          if (bus.Instr[5]) begin
            bj_nxt  = 1'b1;
            off_nxt = imm_ext + PCW'(2);
          end else begin
            fj_nxt  = 1'b1;
            off_nxt = imm_ext;
          end
        end else if (decode && is_halt) begin
          state_nxt = HALTED;
        end
      end
      SHADOW:  state_nxt = RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= RUN;
      flag        <= 1'b0;
      for_jump_q  <= 1'b0;
      back_jump_q <= 1'b0;
      offset_q    <= '0;
      halt_q      <= 1'b0;
      icnt_q      <= '0;
      jcnt_q      <= '0;
    end else begin
      state       <= state_nxt;
      for_jump_q  <= fj_nxt;
      back_jump_q <= bj_nxt;
      offset_q    <= off_nxt;
      halt_q      <= (state_nxt == HALTED);
      if (bus.Flag_We && (state != HALTED))
        flag <= bus.Flag_In;
      // Counters saturate rather than wrap so a long run never reads as short.
      if (bus.Instr_Valid && (state == RUN) && !(&icnt_q))
        icnt_q <= icnt_q + CNTW'(1);
      if (decode && taken && !(&jcnt_q))
        jcnt_q <= jcnt_q + CNTW'(1);
    end
  end

  assign bus.For_Jump    = for_jump_q;
  assign bus.Back_Jump   = back_jump_q;
  assign bus.Offset      = offset_q;
  assign bus.Halt        = halt_q;
  assign bus.Squash      = (state != RUN);
  assign bus.Instr_Count = icnt_q;
  assign bus.Jump_Count  = jcnt_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Drives jump_ctrl from a PC that follows its own jump outputs, checking against a target-level model.
module tb_jump_ctrl;

  localparam logic [8:0] NONCTL = 9'b001_000001;
  localparam logic [8:0] HALTI  = 9'b000_000000;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  jump_ctrl_if #(.PCW(16), .IW(9), .CNTW(16)) bus  ();
  jump_ctrl_if #(.PCW(16), .IW(9), .CNTW(4))  bus4 ();

  jump_ctrl #(.PCW(16), .IW(9), .CNTW(16)) dut  (.CLK(CLK), .Reset(Reset), .bus(bus));
  jump_ctrl #(.PCW(16), .IW(9), .CNTW(4))  dut4 (.CLK(CLK), .Reset(Reset), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Architectural model: what the program should do, in terms of PC targets.
  bit          m_flag, m_halt, m_shadow;
  logic        e_fj, e_bj, e_halt;
  logic [15:0] e_off;
  int          raw_i, raw_j;
  logic [15:0] pc;
  logic [15:0] chk_target, halt_pc;
  int          chk_cnt;
  logic [8:0]  mem [64];

  task automatic model_clear();
    m_flag = 0; m_halt = 0; m_shadow = 0;
    e_fj = 0; e_bj = 0; e_halt = 0; e_off = '0;
    raw_i = 0; raw_j = 0; chk_cnt = 0;
  endtask

  task automatic step(input bit rst, input logic [8:0] ins, input bit vld, input bit we, input bit fin);
    logic [15:0] tgt, pc_nxt, d;
    bit          eflag, was_halt;
    Reset = rst;
    bus.Instr  = ins; bus.Instr_Valid  = vld; bus.Flag_We  = we; bus.Flag_In  = fin;
    bus4.Instr = ins; bus4.Instr_Valid = vld; bus4.Flag_We = we; bus4.Flag_In = fin;
    @(negedge CLK);
    check("squash",     bus.Squash,      32'(m_halt || m_shadow));
    check("for_jump",   bus.For_Jump,    32'(e_fj));
    check("back_jump",  bus.Back_Jump,   32'(e_bj));
    check("offset",     bus.Offset,      32'(e_off));
    check("halt",       bus.Halt,        32'(e_halt));
    check("instr_cnt",  bus.Instr_Count, sat(raw_i, 65535));
    check("jump_cnt",   bus.Jump_Count,  sat(raw_j, 65535));
    check("instr_cnt4", bus4.Instr_Count, sat(raw_i, 15));
    check("jump_cnt4",  bus4.Jump_Count,  sat(raw_j, 15));
    if (chk_cnt == 1) check("pc_target", pc, chk_target);
    if (chk_cnt > 0) chk_cnt--;
    if (m_halt && e_halt) check("pc_frozen", pc, halt_pc);

    if (rst)                pc_nxt = '0;
    else if (bus.Halt)      pc_nxt = pc;
    else if (bus.For_Jump)  pc_nxt = pc + bus.Offset;
    else if (bus.Back_Jump) pc_nxt = pc - bus.Offset;
    else                    pc_nxt = pc + 16'd1;

    if (rst) begin
      model_clear();
    end else begin
      was_halt = m_halt;
      eflag = we ? fin : m_flag;
      e_fj = 0; e_bj = 0; e_off = '0;
      if (m_shadow) begin
        m_shadow = 0;
      end else if (!m_halt && vld) begin
        raw_i++;
        if (ins[8:6] == 3'b111 && (!ins[4] || eflag)) begin
          raw_j++;
          d   = 16'(ins[3:0]) + 16'd1;
          tgt = ins[5] ? pc - d : pc + d;
          if (ins[5]) begin e_bj = 1; e_off = (pc + 16'd1) - tgt; end
          else        begin e_fj = 1; e_off = tgt - (pc + 16'd1); end
          m_shadow   = 1;
          chk_target = tgt;
          chk_cnt    = 2;
        end else if (ins == HALTI) begin
          m_halt  = 1;
          e_halt  = 1;
          halt_pc = pc + 16'd1;
        end
      end
      if (we && !was_halt) m_flag = fin;
    end
    @(posedge CLK);
    #1;
    pc = pc_nxt;
  endtask

  function automatic logic [8:0] rand_instr();
    int          r;
    logic [8:0]  v;
    r = $urandom_range(0, 99);
    if (r < 25) return {3'b111, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
    if (r < 26) return HALTI;
    do v = 9'($urandom); while (v[8:6] == 3'b111 || v == HALTI);
    return v;
  endfunction

  int halted_cycles;

  initial begin
    Reset = 1'b1;
    bus.Instr  = '0; bus.Instr_Valid  = 0; bus.Flag_We  = 0; bus.Flag_In  = 0;
    bus4.Instr = '0; bus4.Instr_Valid = 0; bus4.Flag_We = 0; bus4.Flag_In = 0;
    repeat (2) @(posedge CLK);
    #1;
    model_clear();
    pc = '0;

    // Straight-line code, forward branch at PC=4, back branch at PC=10 with HALT in its shadow.
    step(1, NONCTL, 0, 0, 0);
    repeat (4) step(0, NONCTL, 1, 0, 0);
    step(0, 9'b111_0_0_0011, 1, 0, 0);
    step(0, NONCTL, 1, 0, 0);
    repeat (2) step(0, NONCTL, 1, 0, 0);
    step(0, 9'b111_1_0_0001, 1, 0, 0);
    step(0, HALTI, 1, 0, 0);
    // Conditional branch: same-cycle flag bypass, then not-taken with flag clear.
    step(0, 9'b111_0_1_0010, 1, 1, 1);
    step(0, NONCTL, 1, 1, 0);
    step(0, 9'b111_0_1_0010, 1, 0, 0);
    step(0, NONCTL, 0, 0, 0);
    step(0, NONCTL, 1, 0, 0);
    // HALT freezes everything until reset.
    step(0, HALTI, 1, 0, 0);
    repeat (20) step(0, 9'b111_0_0_0001, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1, NONCTL, 1, 0, 0);
    repeat (2) step(0, NONCTL, 1, 0, 0);
    // Reset landing in the shadow slot.
    step(0, 9'b111_0_0_0101, 1, 0, 0);
    step(1, 9'b111_1_0_0000, 1, 0, 0);
    repeat (3) step(0, NONCTL, 1, 0, 0);

    // Random programs fetched through the PC that the DUT steers.
    for (int ep = 0; ep < 4; ep++) begin
      for (int i = 0; i < 64; i++) mem[i] = rand_instr();
      step(1, NONCTL, 0, 0, 0);
      halted_cycles = 0;
      for (int c = 0; c < 500; c++) begin
        step(($urandom_range(0, 199) == 0) || (halted_cycles > 25),
             mem[pc[5:0]],
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)));
        halted_cycles = m_halt ? halted_cycles + 1 : 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
